// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage owning the PC, the ROM request/grant/response
// handshake and a small instruction buffer feeding decode. Option: IF_FETCH_MISALIGN_CHK_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_data_o,
  output logic [31:0] pc_o
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   req_pc_r, req_pc_s;
  logic [31:0]   target_s;
  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, wr_ptr_s;
  logic [AW-1:0] rd_ptr_r, rd_ptr_s;
  logic [CW-1:0] count_r, count_s;
  logic          push_s, pop_s, space_s;
  logic [63:0]   head_s;
  logic          rom_req_r;
  logic          inst_valid_r;
  logic [31:0]   inst_data_r;
  logic [31:0]   pc_out_r;

  // Redirect target, word-aligned when the misalignment check is built in
  always_comb begin
`ifdef IF_FETCH_MISALIGN_CHK_EN
    target_s = {jump_addr_i[31:2], 2'b00};
`else
    target_s = jump_addr_i;
`endif
  end

  // Buffer push/pop, next pointers and the head entry as it will look after this edge
  always_comb begin
    push_s = (state_r == S_WAIT) && rom_rvalid_i && !jump_flag_i;
    pop_s  = inst_valid_r && !hold_i && !jump_flag_i;
    if (jump_flag_i) begin
      wr_ptr_s = {AW{1'b0}};
      rd_ptr_s = {AW{1'b0}};
      count_s  = {CW{1'b0}};
    end else begin
      wr_ptr_s = wr_ptr_r + AW'(push_s);
      rd_ptr_s = rd_ptr_r + AW'(pop_s);
      count_s  = count_r + CW'(push_s) - CW'(pop_s);
    end
    space_s = (count_s < DEPTH_C);
    // An entry written into an otherwise empty buffer is the next head directly
    if (push_s && (count_s == CW'(1))) begin
      head_s = {req_pc_r, rom_rdata_i};
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Fetch FSM next state and PC update; redirect takes priority everywhere
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    req_pc_s = req_pc_r;
    case (state_r)
      S_IDLE: begin
        if (jump_flag_i) begin
          pc_s    = target_s;
          state_s = S_REQ;
        end else if (space_s) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (rom_gnt_i) begin
          req_pc_s = pc_r;
          if (jump_flag_i) begin
            pc_s    = target_s;
            state_s = S_DROP;
          end else begin
            pc_s    = pc_r + 32'd4;
            state_s = S_WAIT;
          end
        end else if (jump_flag_i) begin
          pc_s    = target_s;
          state_s = S_REQ;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (jump_flag_i) begin
          pc_s    = target_s;
          state_s = rom_rvalid_i ? S_REQ : S_DROP;
        end else if (rom_rvalid_i) begin
          state_s = space_s ? S_REQ : S_IDLE;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DROP: begin
        // Only one stale response can be in flight, so a response here always ends the drop
        if (jump_flag_i) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        state_s = rom_rvalid_i ? S_REQ : S_DROP;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state, PC and buffer bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= 32'h0000_0000;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
    end
  end

  // Instruction buffer storage, {pc, inst} per entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r <= '{default: 64'h0};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {req_pc_r, rom_rdata_i};
    end else begin
      mem_r <= mem_r;
    end
  end

  // Registered outputs toward ROM and decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_req_r    <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_data_r  <= NOP_INST;
      pc_out_r     <= 32'h0000_0000;
    end else begin
      rom_req_r    <= (state_s == S_REQ);
      inst_valid_r <= (count_s != {CW{1'b0}});
      inst_data_r  <= (count_s != {CW{1'b0}}) ? head_s[31:0] : NOP_INST;
      pc_out_r     <= (count_s != {CW{1'b0}}) ? head_s[63:32] : 32'h0000_0000;
    end
  end

  assign rom_req_o    = rom_req_r;
  assign rom_addr_o   = pc_r;
  assign inst_valid_o = inst_valid_r;
  assign inst_data_o  = inst_data_r;
  assign pc_o         = pc_out_r;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic misalign_r;

  // One-cycle pulse for a redirect to a non-word-aligned target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= jump_flag_i && (jump_addr_i[1:0] != 2'b00);
    end
  end

  assign misalign_o = misalign_r;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a behavioural ROM with configurable grant stall and
// response latency, and a queue of expected {pc, inst} checked as decode consumes.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic [31:0] pc_o;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_gnt_i    (rom_gnt_i),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_rdata_i  (rom_rdata_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_i       (hold_i),
    .inst_valid_o (inst_valid_o),
    .inst_data_o  (inst_data_o),
    .pc_o         (pc_o)
`ifdef IF_FETCH_MISALIGN_CHK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  int          stall_cnt;
  int          rsp_lat;
  int          pend_cnt;
  logic        pend_v;
  logic [31:0] pend_addr;
  int          n_pop = 0;
  logic [31:0] last_pop_pc;
  int          base;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive ROM for this cycle, update scoreboard, advance to next negedge
  task automatic run_cycle();
    logic [63:0] e;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0000_0000;
    if (pend_v) begin
      if (pend_cnt == 0) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i  = rom_fn(pend_addr);
        pend_v       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    rom_gnt_i = 1'b0;
    if (rom_req_o) begin
      if (stall_cnt > 0) begin
        stall_cnt--;
      end else begin
        rom_gnt_i = 1'b1;
        pend_v    = 1'b1;
        pend_cnt  = rsp_lat - 1;
        pend_addr = rom_addr_o;
      end
    end
    if (jump_flag_i) begin
      exp_q.delete();
    end else begin
      if (inst_valid_o && !hold_i) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed pc=%08h expected=<none>", pc_o);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pop_pc", pc_o, e[63:32]);
          chk("pop_inst", inst_data_o, e[31:0]);
        end
        n_pop++;
        last_pop_pc = pc_o;
      end
      if (rom_gnt_i) exp_q.push_back({rom_addr_o, rom_fn(rom_addr_o)});
    end
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!rom_req_o && k < 50) begin
      run_cycle();
      k++;
    end
    chk(tag, 32'(rom_req_o), 32'd1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    int k = 0;
    while (n_pop < target && k < 100) begin
      run_cycle();
      k++;
    end
    chk(tag, 32'(n_pop), 32'(target));
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    rom_gnt_i    = 1'b0;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0000_0000;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 32'h0000_0000;
    hold_i       = 1'b0;
    pend_v       = 1'b0;
    pend_cnt     = 0;
    stall_cnt    = 0;
    rsp_lat      = 1;
    exp_q.delete();
    #1;
    chk("rst_req", 32'(rom_req_o), 32'd0);
    chk("rst_addr", rom_addr_o, 32'h0000_0000);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_data_o, NOP);
    chk("rst_pc", pc_o, 32'h0000_0000);
`ifdef IF_FETCH_MISALIGN_CHK_EN
    chk("rst_misalign", 32'(misalign_o), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    rom_gnt_i    = 1'b0;
    rom_rvalid_i = 1'b0;
    rom_rdata_i  = 32'h0000_0000;
    jump_flag_i  = 1'b0;
    jump_addr_i  = 32'h0000_0000;
    hold_i       = 1'b0;
    @(negedge clk);
    do_reset();

    // First fetch: request at 0, data valid two cycles after request rises
    wait_req("t1_req");
    chk("t1_addr0", rom_addr_o, 32'h0000_0000);
    run_cycle();
    chk("t1_req_low", 32'(rom_req_o), 32'd0);
    run_cycle();
    chk("t1_valid", 32'(inst_valid_o), 32'd1);
    chk("t1_pc", pc_o, 32'h0000_0000);
    chk("t1_inst", inst_data_o, 32'h0050_0093);
    chk("t1_req2", 32'(rom_req_o), 32'd1);
    chk("t1_addr4", rom_addr_o, 32'h0000_0004);

    // Hold: buffer fills to two entries and requests stop
    hold_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) chk("t2_req_full", 32'(rom_req_o), 32'd0);
      run_cycle();
    end
    chk("t2_buffered", 32'(exp_q.size()), 32'd2);
    chk("t2_valid", 32'(inst_valid_o), 32'd1);
    chk("t2_head_pc", pc_o, 32'h0000_0000);
    base   = n_pop;
    hold_i = 1'b0;
    wait_pops(base + 3, "t2_pops");
    chk("t2_last_pc", last_pop_pc, 32'h0000_0008);

    // Redirect while waiting for the response to 0x8
    do_reset();
    rsp_lat = 3;
    begin
      int k = 0;
      while (!(rom_req_o && rom_addr_o == 32'h0000_0008) && k < 100) begin
        run_cycle();
        k++;
      end
    end
    chk("t3_addr8", rom_addr_o, 32'h0000_0008);
    run_cycle();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    run_cycle();
    jump_flag_i = 1'b0;
    chk("t3_req_low", 32'(rom_req_o), 32'd0);
    chk("t3_valid_low", 32'(inst_valid_o), 32'd0);
    wait_req("t3_req");
    chk("t3_req_addr", rom_addr_o, 32'h0000_0100);
    base = n_pop;
    wait_pops(base + 1, "t3_pop");
    chk("t3_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect in the same cycle as the response
    do_reset();
    hold_i = 1'b1;
    wait_req("t4_req");
    run_cycle();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    run_cycle();
    jump_flag_i = 1'b0;
    chk("t4_valid_low", 32'(inst_valid_o), 32'd0);
    chk("t4_req", 32'(rom_req_o), 32'd1);
    chk("t4_addr", rom_addr_o, 32'h0000_0200);
    hold_i = 1'b0;
    base   = n_pop;
    wait_pops(base + 1, "t4_pop");
    chk("t4_first_pc", last_pop_pc, 32'h0000_0200);

    // Grant withheld: request stable; PC wraps past 0xFFFF_FFFC
    do_reset();
    stall_cnt = 1000;
    wait_req("t5_req");
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFF8;
    run_cycle();
    jump_flag_i = 1'b0;
    stall_cnt   = 3;
    for (int i = 0; i < 3; i++) begin
      chk("t5_req_stable", 32'(rom_req_o), 32'd1);
      chk("t5_addr_stable", rom_addr_o, 32'hFFFF_FFF8);
      run_cycle();
    end
    base = n_pop;
    wait_pops(base + 3, "t5_pops");
    chk("t5_wrap_pc", last_pop_pc, 32'h0000_0000);

    // Back-to-back redirects with a valid head: last target wins, one stale drop
    do_reset();
    rsp_lat = 3;
    hold_i  = 1'b1;
    begin
      int k = 0;
      while (!inst_valid_o && k < 50) begin
        run_cycle();
        k++;
      end
    end
    chk("t6_valid", 32'(inst_valid_o), 32'd1);
    run_cycle();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0300;
    run_cycle();
    chk("t6_valid_drop", 32'(inst_valid_o), 32'd0);
    chk("t6_addr1", rom_addr_o, 32'h0000_0300);
    jump_addr_i = 32'h0000_0400;
    run_cycle();
    jump_flag_i = 1'b0;
    chk("t6_addr2", rom_addr_o, 32'h0000_0400);
    chk("t6_req_low", 32'(rom_req_o), 32'd0);
    wait_req("t6_req");
    chk("t6_req_addr", rom_addr_o, 32'h0000_0400);
    hold_i = 1'b0;
    base   = n_pop;
    wait_pops(base + 1, "t6_pop");
    chk("t6_first_pc", last_pop_pc, 32'h0000_0400);

`ifdef IF_FETCH_MISALIGN_CHK_EN
    // Misaligned redirect target is flagged and aligned
    do_reset();
    stall_cnt = 1000;
    wait_req("t7_req");
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0102;
    run_cycle();
    jump_flag_i = 1'b0;
    chk("t7_misalign", 32'(misalign_o), 32'd1);
    chk("t7_addr", rom_addr_o, 32'h0000_0100);
    run_cycle();
    chk("t7_misalign_pulse", 32'(misalign_o), 32'd0);
`endif

    // Reset in the middle of traffic returns everything to reset values
    rsp_lat = 2;
    run_cycle();
    run_cycle();
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
